// File: rtl/wait_after_reset_pkg.sv
// Shared types and helpers for the wait-after-reset controller.
// Holds the sequencer phase enum and the counter width helper.
package wait_after_reset_pkg;

  typedef enum logic [1:0] {
    PH_LO   = 2'd0,
    PH_HI   = 2'd1,
    PH_DONE = 2'd2
  } phase_e;

  // Bits needed to hold 0..n, never less than one.
  function automatic int cnt_width(input int n);
    if (n < 1) return 1;
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/wait_cycles_timer.sv
// Retriggerable countdown: ready_r_o drops for cycles_p cycles per trigger.
// Ports: clk, reset (sync, high), activate_i trigger, ready_r_o idle flag.
module wait_cycles_timer
  import wait_after_reset_pkg::*;
#(
  parameter int cycles_p = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic activate_i,
  output logic ready_r_o
);

  localparam int cnt_w = cnt_width(cycles_p);
  localparam logic [cnt_w-1:0] load =
    cnt_w'((cycles_p == 0) ? 0 : cycles_p - 1);

  logic [cnt_w-1:0] cnt;

  // The trigger edge itself is the first low cycle, so the
  // counter is loaded with cycles_p-1 and ready returns on
  // the edge after it reaches zero. A zero-length timer
  // never leaves the idle state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      ready_r_o <= 1'b1;
    end else if (activate_i && (cycles_p != 0)) begin
      cnt       <= load;
      ready_r_o <= 1'b0;
    end else if (!ready_r_o) begin
      if (cnt == '0) begin
        ready_r_o <= 1'b1;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/wait_after_reset_ctrl.sv
// Post-reset sequencer: emits a reset_o pulse, waits, then flags ready.
// Ports: clk, reset, activate_i in; reset_o, ready_r_o, activate_o, done_r_o out.
module wait_after_reset_ctrl
  import wait_after_reset_pkg::*;
#(
  parameter int reset_cycles_lo_p = 1,
  parameter int reset_cycles_hi_p = 5,
  parameter int lg_wait_cycles_p  = 1,
  parameter int cycles_p          = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic activate_i,
  output logic reset_o,
  output logic ready_r_o,
  output logic activate_o,
  output logic done_r_o
);

  localparam int seq_max =
    (reset_cycles_lo_p > reset_cycles_hi_p)
      ? reset_cycles_lo_p : reset_cycles_hi_p;
  localparam int seq_w = cnt_width(seq_max);
  localparam logic [seq_w-1:0] lo_last =
    seq_w'(reset_cycles_lo_p - 1);
  localparam logic [seq_w-1:0] hi_last =
    seq_w'(reset_cycles_hi_p - 1);

  localparam int wait_w = lg_wait_cycles_p + 1;
  localparam logic [wait_w-1:0] wait_tgt =
    wait_w'(1 << lg_wait_cycles_p);

  phase_e           phase_q;
  phase_e           phase_d;
  logic [seq_w-1:0] seq_q;
  logic [seq_w-1:0] seq_d;
  logic             rst_d;

  logic [wait_w-1:0] wait_q;
  logic [wait_w-1:0] wait_d;
  logic              ready_d;
  logic              act_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= PH_LO;
      seq_q   <= '0;
      reset_o <= 1'b0;
    end else begin
      phase_q <= phase_d;
      seq_q   <= seq_d;
      reset_o <= rst_d;
    end
  end

  // reset_o is registered from the next-phase decision so it
  // rises on edge lo and falls on edge lo+hi.
  always_comb begin
    phase_d = phase_q;
    seq_d   = seq_q;
    rst_d   = 1'b0;
    unique case (phase_q)
      PH_LO: begin
        if (seq_q == lo_last) begin
          phase_d = PH_HI;
          seq_d   = '0;
          rst_d   = 1'b1;
        end else begin
          seq_d = seq_q + 1'b1;
        end
      end
      PH_HI: begin
        rst_d = 1'b1;
        if (seq_q == hi_last) begin
          phase_d = PH_DONE;
          seq_d   = '0;
          rst_d   = 1'b0;
        end else begin
          seq_d = seq_q + 1'b1;
        end
      end
      PH_DONE: begin
        phase_d = PH_DONE;
      end
      default: begin
        phase_d = PH_LO;
        seq_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q     <= '0;
      ready_r_o  <= 1'b0;
      activate_o <= 1'b0;
    end else begin
      wait_q     <= wait_d;
      ready_r_o  <= ready_d;
      activate_o <= act_d;
    end
  end

  // The low cycles before the pulse must not count toward the
  // wait, so counting only starts once the pulse has finished.
  always_comb begin
    wait_d  = wait_q;
    ready_d = ready_r_o;
    act_d   = 1'b0;
    if (reset_o) begin
      wait_d = '0;
    end else if ((phase_q == PH_DONE) && (wait_q != wait_tgt)) begin
      wait_d = wait_q + 1'b1;
      if ((wait_d == wait_tgt) && !ready_r_o) begin
        ready_d = 1'b1;
        act_d   = 1'b1;
      end
    end
  end

  wait_cycles_timer #(
    .cycles_p (cycles_p)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .activate_i (activate_o | activate_i),
    .ready_r_o  (done_r_o)
  );

endmodule

// File: tb/tb_wait_after_reset_ctrl.sv
// Directed bench for wait_after_reset_ctrl across several parameter sets.
// Expected values come from the edge-numbered timing of each output.
module tb_wait_after_reset_ctrl;

  localparam int ND = 5;
  localparam int LO[ND]  = '{1, 1, 1, 2, 1};
  localparam int HI[ND]  = '{5, 5, 5, 3, 5};
  localparam int LG[ND]  = '{1, 1, 0, 3, 2};
  localparam int CYC[ND] = '{3, 0, 3, 8, 1};

  logic clk;
  logic reset;
  logic act_in;
  logic ro [ND];
  logic rd [ND];
  logic ao [ND];
  logic dn [ND];

  int n;
  int n_vec;
  int n_bad;
  int ext_q[$];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    wait_after_reset_ctrl #(
      .reset_cycles_lo_p (LO[g]),
      .reset_cycles_hi_p (HI[g]),
      .lg_wait_cycles_p  (LG[g]),
      .cycles_p          (CYC[g])
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .activate_i (act_in),
      .reset_o    (ro[g]),
      .ready_r_o  (rd[g]),
      .activate_o (ao[g]),
      .done_r_o   (dn[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s edge %0d: got %b want %b", tag, n, got, exp);
    end
  endtask

  function automatic bit exp_rst(input int e, input int i);
    return (e >= LO[i]) && (e <= LO[i] + HI[i] - 1);
  endfunction

  function automatic int rise_edge(input int i);
    return LO[i] + HI[i] + (1 << LG[i]);
  endfunction

  function automatic bit exp_rdy(input int e, input int i);
    return (e >= 1) && (e >= rise_edge(i));
  endfunction

  function automatic bit exp_act(input int e, input int i);
    return e == rise_edge(i);
  endfunction

  function automatic bit exp_done(input int e, input int i);
    int last;
    last = -1;
    if (e >= 1 && rise_edge(i) + 1 <= e) last = rise_edge(i) + 1;
    foreach (ext_q[k])
      if (ext_q[k] <= e && ext_q[k] > last) last = ext_q[k];
    if (CYC[i] == 0 || last < 0) return 1'b1;
    return (e - last) >= CYC[i];
  endfunction

  task automatic check_all();
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("u%0d_reset_o", i), ro[i], exp_rst(n, i));
      chk($sformatf("u%0d_ready", i), rd[i], exp_rdy(n, i));
      chk($sformatf("u%0d_act", i), ao[i], exp_act(n, i));
      chk($sformatf("u%0d_done", i), dn[i], exp_done(n, i));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!reset) n++;
    check_all();
  endtask

  task automatic run(input int edges);
    for (int k = 0; k < edges; k++) begin
      act_in = 1'b0;
      foreach (ext_q[j])
        if (ext_q[j] == n + 1) act_in = 1'b1;
      step();
    end
    act_in = 1'b0;
  endtask

  initial begin
    n_vec  = 0;
    n_bad  = 0;
    n      = 0;
    reset  = 1'b1;
    act_in = 1'b0;

    // Reset values, including an activate_i pulse under reset.
    step();
    act_in = 1'b1;
    step();
    act_in = 1'b0;
    step();

    // Full sequence with external triggers, one restarting a count.
    ext_q = '{11, 22, 26};
    reset = 1'b0;
    run(40);

    // Abort mid-sequence: reset after edge 4 for two edges.
    ext_q = {};
    reset = 1'b1;
    n = 0;
    step();
    reset = 1'b0;
    run(4);
    reset = 1'b1;
    n = 0;
    step();
    step();
    reset = 1'b0;
    run(24);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wait_after_reset_ctrl.md
WAIT_AFTER_RESET_CTRL -- requirements
Module: wait_after_reset_ctrl

Interface
REQ-001 The block SHALL have parameter reset_cycles_lo_p, default 1: cycles reset_o stays low after reset release before pulsing; legal range >=1.
REQ-002 The block SHALL have parameter reset_cycles_hi_p, default 5: width in cycles of the reset_o pulse; legal range >=1.
REQ-003 The block SHALL have parameter lg_wait_cycles_p, default 1: log2 of the cycles waited after reset_o falls before ready_r_o rises; legal range 0..16.
REQ-004 The block SHALL have parameter cycles_p, default 3: timer length in cycles after an activation; legal range 0..2^16-1.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 reset  input  1  reset; synchronous, active-high.
REQ-007 activate_i  input  1  external timer trigger, sampled each rising edge.
REQ-008 reset_o  output  1  generated downstream reset pulse, registered.
REQ-009 ready_r_o  output  1  high once the post-reset wait has elapsed, sticky until reset.
REQ-010 activate_o  output  1  single-cycle pulse marking ready_r_o rising.
REQ-011 done_r_o  output  1  timer idle/expired flag, registered.

Function
REQ-012 Edges are numbered n=1,2,... starting at the first rising edge sampling reset=0.
REQ-013 Reset sequencer SHALL use phases LO, HI, DONE; LO on reset.
REQ-014 reset_o SHALL be 0 after edges 1..lo-1, 1 after edges lo..lo+hi-1, and 0 permanently from edge lo+hi (phase DONE).
REQ-015 Wait counter of lg_wait_cycles_p+1 bits SHALL clear whenever reset_o is 1 at the sampling edge and increment on each edge sampling reset_o=0 until it reaches 2^lg_wait_cycles_p, then saturate.
REQ-016 ready_r_o SHALL be 1 after the edge at which the counter reaches 2^lg_wait_cycles_p, and stay 1 until reset.
REQ-017 activate_o SHALL be 1 for exactly the one cycle following the edge at which ready_r_o goes 0->1; never otherwise.
REQ-018 Timer trigger SHALL be activate_o OR activate_i, sampled at a rising edge.
REQ-019 With cycles_p>0, a trigger sampled at edge E SHALL drive done_r_o 0 after edge E and 1 after edge E+cycles_p.
REQ-020 A trigger sampled while the timer is counting SHALL restart the count from that edge.
REQ-021 With cycles_p=0, done_r_o SHALL remain 1 regardless of triggers.
REQ-022 The timer counter SHALL be $clog2(cycles_p+1) bits (min 1) and never wrap.

Reset
REQ-023 While reset=1 at an edge: reset_o=0, phase=LO, wait counter=0, ready_r_o=0, activate_o=0, timer idle, done_r_o=1.
REQ-024 Reset asserted mid-sequence or mid-timer SHALL abort it; the full sequence SHALL restart from edge 1 after release.

Structure
REQ-025 Phase enum (LO/HI/DONE) SHALL live in shared package wait_after_reset_pkg.
REQ-026 The cycles_p timer SHALL be sub-module wait_cycles_timer (clk, reset, activate_i, ready_r_o).
REQ-027 All outputs SHALL be driven directly from flops; no combinational input-to-output paths.

Verification
REQ-028 Defaults (lo=1, hi=5, lg=1, cycles=3), activate_i=0 -> reset_o 1 after edges 1..5, 0 from edge 6; ready_r_o 1 after edge 8; activate_o 1 only after edge 8; done_r_o 0 after edge 9, 1 after edge 12.
REQ-029 Defaults, activate_i pulsed at edge 11 -> done_r_o stays 0, returns 1 after edge 14.
REQ-030 cycles_p=0 -> done_r_o constant 1 across the whole sequence and activate_i pulses.
REQ-031 lg_wait_cycles_p=0 -> ready_r_o 1 after edge 7, activate_o 1 only after edge 7.
REQ-032 reset reasserted after edge 4 for 2 cycles, then released -> all outputs at reset values; sequence repeats exactly as REQ-028 from the new edge 1.
REQ-033 Sweep lg_wait_cycles_p 0..3 and cycles_p 0..8 -> ready_r_o rise at edge lo+hi+2^lg and done_r_o low for exactly cycles_p cycles per trigger.
